// File: rtl/lut_layer_sched.sv
// Time-multiplexed evaluator for one layer of 1-bit FANIN-input LUT neurons.
// Ports: clk/rst, cfg_* table write port with cfg_err pulse, in_* vector
// handshake, out_* result handshake, busy while not idle.
module lut_layer_sched #(
    parameter int NUM_NEURONS = 8,
    parameter int FANIN       = 6
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_we,
    input  logic [$clog2(NUM_NEURONS)+FANIN-1:0]   cfg_addr,
    input  logic                                   cfg_data,
    output logic                                   cfg_err,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_NEURONS*FANIN-1:0]           in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_NEURONS-1:0]                 out_data,
    output logic                                   busy
);

    localparam int NIDX_W = $clog2(NUM_NEURONS);
    localparam int AW     = NIDX_W + FANIN;
    localparam int DEPTH  = NUM_NEURONS << FANIN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [NIDX_W:0]   LP_N    = (NIDX_W+1)'(NUM_NEURONS);
    localparam logic [NIDX_W-1:0] LP_LAST = NIDX_W'(NUM_NEURONS - 1);

    logic [1:0]                   r_state;
    logic [NIDX_W-1:0]            r_cnt;
    logic [NUM_NEURONS*FANIN-1:0] r_in;
    logic                         r_rd;
    logic [NIDX_W-1:0]            r_rd_idx;
    logic                         r_rd_vld;
    logic [NUM_NEURONS-1:0]       r_out_data;
    logic                         r_out_valid;
    logic                         r_cfg_err;
    logic                         r_mem [DEPTH];

    logic              w_idle;
    logic              w_cfg_ok;
    logic [NIDX_W-1:0] w_cfg_idx;
    logic [FANIN-1:0]  w_entry;
    logic [AW-1:0]     w_rd_addr;

    assign w_idle    = (r_state == S_IDLE);
    assign w_cfg_idx = cfg_addr[AW-1:FANIN];
    assign w_cfg_ok  = cfg_we & w_idle & ({1'b0, w_cfg_idx} < LP_N);
    assign w_rd_addr = {r_cnt, w_entry};

    // Select the latched address field of the neuron being evaluated.
    always_comb begin
        w_entry = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (r_cnt == NIDX_W'(k)) begin
                w_entry = r_in[k*FANIN +: FANIN];
            end
        end
    end

    // Shared truth-table store: never reset, written only in IDLE,
    // read only outside IDLE, so no read-during-write hazard exists.
    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            r_mem[cfg_addr] <= cfg_data;
        end
        r_rd <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in        <= '0;
            r_rd_idx    <= '0;
            r_rd_vld    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we & ~w_cfg_ok;
            // Read issued in EVAL lands one cycle later; tag it with its neuron.
            r_rd_vld  <= (r_state == S_EVAL);
            r_rd_idx  <= r_cnt;
            if (r_rd_vld) begin
                r_out_data[r_rd_idx] <= r_rd;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_in    <= in_data;
                        r_cnt   <= '0;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (r_cnt == LP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_idle & ~cfg_we;
    assign busy      = ~w_idle;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cfg_err   = r_cfg_err;

endmodule

// File: doc/lut_layer_sched.md
Name: lut_layer_sched

Overview:
- Time-multiplexed evaluator for one LogicNets layer of 1-bit-output, FANIN-input LUT neurons.
- All neuron truth tables live in a single shared synchronous-read table memory of NUM_NEURONS x 2^FANIN bits; one neuron is evaluated per cycle.
- Truth tables are loaded at runtime through a config write port. Input and output vectors use valid/ready handshakes.
- Sits between the per-neuron fan-in gather logic (upstream) and the next layer or output register (downstream).

Parameters:
- NUM_NEURONS, 8, neurons in the layer (>=2)
- FANIN, 6, input bits per neuron; table depth per neuron is 2^FANIN
- NIDX_W, clog2(NUM_NEURONS), localparam, neuron index width

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  NIDX_W+FANIN  {neuron index, table entry}
- cfg_data  in  1  table bit to write
- cfg_err  out  1  one-cycle pulse: rejected config write
- in_valid  in  1  input vector valid
- in_ready  out  1  input vector accepted when in_valid&in_ready
- in_data  in  NUM_NEURONS*FANIN  neuron k address = in_data[k*FANIN +: FANIN]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  NUM_NEURONS  bit k = table_k[address_k]
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - State IDLE; out_valid=0, out_data=0, cfg_err=0, busy=0; eval counter=0.
  - Table memory is not reset: contents are undefined until written.
  - rst mid-operation aborts evaluation; no out_valid is produced.
- States: IDLE -> EVAL -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready = (state==IDLE) & !cfg_we. Config has priority over input acceptance in the same cycle.
  - Acceptance at cycle T: in_data is latched, counter is cleared, next state is EVAL.
- EVAL, cycles T+1 .. T+NUM_NEURONS:
  - Cycle T+1+k issues a read of table entry {k, addr_k}.
  - Read data returns the following cycle and is written to out_data[k].
  - Counter increments each cycle; at k=NUM_NEURONS-1 the next state is DRAIN.
- DRAIN, one cycle:
  - Captures the last read result.
  - out_valid rises at cycle T+NUM_NEURONS+2. Latency from acceptance to out_valid is NUM_NEURONS+2 cycles.
- DONE:
  - out_valid=1 and out_data are held stable until out_ready=1.
  - On the handshake cycle, next state is IDLE and out_valid drops the next cycle.
  - out_data keeps its last value after the handshake.
  - Minimum initiation interval is NUM_NEURONS+3 cycles with out_ready tied high.
- Config writes:
  - Accepted only in IDLE and only when the neuron index < NUM_NEURONS. The write takes effect at the clock edge.
  - A cfg_we in any other state, or with index >= NUM_NEURONS, is ignored: the memory is unchanged and cfg_err pulses high for exactly the next cycle.
  - Back-to-back writes are allowed, one per cycle.
- Read-during-write cannot occur, because reads happen only outside IDLE and writes only in IDLE.
- in_valid outside IDLE is ignored (in_ready=0). The upstream must hold in_valid and in_data until accepted.
- The counter never wraps: the EVAL exit is decided on the compare at NUM_NEURONS-1.

Test Plan (NUM_NEURONS=4, FANIN=6):
1. Reset then idle:
   - Stimulus: rst high 2 cycles, then low.
   - Required: out_valid=0, out_data=4'b0000, in_ready=1, busy=0, cfg_err=0.
2. Load and evaluate, out_ready held high:
   - Load: all tables zero; then set N0[1]=1, N1[63]=1, N2[0]=1, N3[42]=1.
   - Stimulus: addresses {N3=42, N2=5, N1=63, N0=1}, accepted at cycle T.
   - Required: out_valid first high at T+6, out_data=4'b1011; back in IDLE with in_ready=1 at T+7.
3. Output backpressure:
   - Stimulus: same vector as scenario 2, with out_ready=0 for 10 cycles after out_valid.
   - Required: out_valid and out_data=4'b1011 stay stable all 10 cycles; in_ready=0 throughout.
   - Then out_ready=1 for one cycle -> out_valid=0 the next cycle.
4. Illegal config writes:
   - Write during EVAL -> cfg_err pulses one cycle; a re-evaluation shows the table unchanged.
   - Write with cfg_addr neuron index 5 (with NUM_NEURONS=5 build, index 5 >= 5) -> cfg_err pulse; no memory change.
5. Config/input collision:
   - Stimulus: in IDLE, cfg_we=1 and in_valid=1 in the same cycle.
   - Required: the write lands, in_ready=0 that cycle; the input is accepted the next cycle and its result uses the new table bit.
6. Reset mid-EVAL:
   - Stimulus: assert rst at T+2.
   - Required: no out_valid; the next cycle shows busy=0, in_ready=1.
   - Tables retain their contents: re-running scenario 2 gives 4'b1011.
